// File: rtl/fp_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_normalize_round
//   Sequential normalize-and-round stage that sits after the FP add/sub sum.
//   It takes a raw sign/exponent/mantissa and handles it as follows:
//     - Normalizes it one bit per cycle.
//     - Rounds the result to nearest-even.
//     - Packs an IEEE-754 single-precision word.
//     - Raises overflow (saturate to infinity) and underflow (flush to zero).
//
//   Optional feature: define FP_INEXACT_EN to add the inexact_o flag.
//
//   Ports:
//     clk_i        system clock, rising edge
//     rst_n        asynchronous active-low reset
//     start_i      request, sampled only while idle and not busy
//     sign_i       sign of the raw result
//     exp_i[8:0]   biased exponent (bit 8 carries pre-overflow values)
//     mant_i[26:0] {carry, hidden, fraction[22:0], guard, sticky}
//     busy_o       high from the cycle after acceptance through the done cycle
//     done_o       one-cycle pulse; result and flags are valid with it
//     result_o     packed single {sign, exp[7:0], frac[22:0]}
//     overflow_o   result saturated to infinity
//     underflow_o  result flushed to zero
//     inexact_o    (FP_INEXACT_EN only) precision was lost
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_normalize_round #(
    parameter int MAX_LEFT_SHIFTS = 26
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        sign_i,
    input  logic [8:0]  exp_i,
    input  logic [26:0] mant_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        overflow_o,
`ifdef FP_INEXACT_EN
    output logic        inexact_o,
`endif
    output logic        underflow_o
);

    localparam int CNT_W = $clog2(MAX_LEFT_SHIFTS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [9:0]         exp_q, exp_d;
    logic [26:0]        mant_q, mant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef FP_INEXACT_EN
    logic               inx_q, inx_d;
`endif

    logic               accept_s;
    logic               shift_ok_s;
    logic               round_up_s;
    logic [24:0]        rounded_s;
    logic [9:0]         exp_rnd_s;
    logic [22:0]        frac_rnd_s;

    // busy_q stays high through the done cycle, so a start there is ignored
    assign accept_s   = (state_q == IDLE) && start_i && !busy_q;
    assign shift_ok_s = (exp_q > 10'd1) && (cnt_q < CNT_W'(MAX_LEFT_SHIFTS));

    // Round-to-nearest-even on mant[24:2]. The carry bit is always 0 in ROUND,
    // so rounded_s[24] marks the increment carrying past the hidden bit.
    assign round_up_s = mant_q[1] & (mant_q[0] | mant_q[2]);
    assign rounded_s  = mant_q[26:2] + {24'd0, round_up_s};
    assign exp_rnd_s  = exp_q + {9'd0, rounded_s[24]};
    assign frac_rnd_s = rounded_s[24] ? rounded_s[23:1] : rounded_s[22:0];

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 10'd0;
            mant_q   <= 27'd0;
            cnt_q    <= '0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FP_INEXACT_EN
            inx_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FP_INEXACT_EN
            inx_q    <= inx_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = NORM;
                else          state_d = IDLE;
            end
            NORM: begin
                if (mant_q == 27'd0)  state_d = DONE;
                else if (mant_q[26])  state_d = ROUND;
                else if (mant_q[25])  state_d = ROUND;
                else if (shift_ok_s)  state_d = NORM;
                else                  state_d = DONE;
            end
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
`ifdef FP_INEXACT_EN
        inx_d    = inx_q;
`endif
        // done is registered from DONE, so it lands one cycle after that state
        done_d   = (state_q == DONE);
        busy_d   = (state_d != IDLE) || (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sign_d = sign_i;
                    exp_d  = {1'b0, exp_i};
                    mant_d = mant_i;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
`ifdef FP_INEXACT_EN
                    inx_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            NORM: begin
                if (mant_q == 27'd0) begin
                    result_d = {sign_q, 31'd0};
                end else if (mant_q[26]) begin
                    // Guard folds into sticky as the mantissa shifts right
                    mant_d = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 10'd1;
                end else if (mant_q[25]) begin
                    mant_d = mant_q;
                end else if (shift_ok_s) begin
                    mant_d = {mant_q[25:0], 1'b0};
                    exp_d  = exp_q - 10'd1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
`ifdef FP_INEXACT_EN
                    inx_d    = 1'b1;
`endif
                end
            end
            ROUND: begin
                if (exp_rnd_s >= 10'd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
`ifdef FP_INEXACT_EN
                    inx_d    = 1'b1;
`endif
                end else begin
                    result_d = {sign_q, exp_rnd_s[7:0], frac_rnd_s};
`ifdef FP_INEXACT_EN
                    inx_d    = mant_q[1] | mant_q[0];
`endif
                end
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`ifdef FP_INEXACT_EN
    assign inexact_o   = inx_q;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
`timescale 1ns/1ps
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [8:0]  exp_v = 9'd0;
    logic [26:0] mant = 27'd0;
    logic        busy_o, done_o, overflow_o, underflow_o;
    logic [31:0] result_o;
`ifdef FP_INEXACT_EN
    logic        inexact_o;
`endif

    fp_normalize_round #(.MAX_LEFT_SHIFTS(26)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .sign_i      (sign),
        .exp_i       (exp_v),
        .mant_i      (mant),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .overflow_o  (overflow_o),
`ifdef FP_INEXACT_EN
        .inexact_o   (inexact_o),
`endif
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic ovf, input logic unf,
                                input logic inx, input int lat);
        exp_t r;
        r = '0;
        r.res = res; r.ovf = ovf; r.unf = unf; r.inx = inx; r.lat = lat;
        return r;
    endfunction

    // Reference: find the leading one, normalize in one step, round with integer math
    function automatic exp_t model(input logic s, input logic [8:0] e_in, input logic [26:0] m_in);
        exp_t        r;
        int          e, p, need, avail;
        longint      m, sig;
        logic        g, st;
        logic [31:0] eb;
        logic [31:0] sb32;
        r = '0;
        e = int'(e_in);
        m = longint'(m_in);
        need = 0;
        if (m == 0) begin
            r.res = {s, 31'd0};
            r.lat = 3;
            return r;
        end
        if (m_in[26]) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else begin
            p = 25;
            while (p > 0 && m_in[p] == 1'b0) p--;
            need  = 25 - p;
            avail = (e > 1) ? e - 1 : 0;
            if (avail > 26) avail = 26;
            if (need > avail) begin
                r.res = {s, 31'd0};
                r.unf = 1'b1;
                r.inx = 1'b1;
                r.lat = 3 + avail;
                return r;
            end
            m = m << need;
            e = e - need;
        end
        g   = ((m >> 1) & 1) != 0;
        st  = (m & 1) != 0;
        sig = (m >> 2) & 64'hFFFFFF;
        if (g && (st || ((sig & 1) != 0))) sig = sig + 1;
        if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        r.lat = 4 + need;
        r.inx = g | st;
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else begin
            eb    = 32'(e);
            sb32  = 32'(sig);
            r.res = {s, eb[7:0], sb32[22:0]};
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT signals done
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                mon_x = sb.pop_front();
                check("result",    64'(result_o),    64'(mon_x.res));
                check("overflow",  64'(overflow_o),  64'(mon_x.ovf));
                check("underflow", 64'(underflow_o), 64'(mon_x.unf));
`ifdef FP_INEXACT_EN
                check("inexact",   64'(inexact_o),   64'(mon_x.inx));
`endif
                check("latency",   64'(cyc - mon_x.t0), 64'(mon_x.lat));
                check("busy_at_done", 64'(busy_o), 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("timeout_idle", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic s, input logic [8:0] e, input logic [26:0] m, input exp_t x);
        exp_t y;
        @(negedge clk);
        sign = s; exp_v = e; mant = m; start = 1'b1;
        y = x;
        y.t0 = cyc;
        sb.push_back(y);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},   64'(busy_o),      64'd0);
        check({tag, "_done"},   64'(done_o),      64'd0);
        check({tag, "_result"}, 64'(result_o),    64'd0);
        check({tag, "_ovf"},    64'(overflow_o),  64'd0);
        check({tag, "_unf"},    64'(underflow_o), 64'd0);
    endtask

    initial begin
        int          p, sel, n;
        logic        s;
        logic [8:0]  e;
        logic [26:0] m;
        logic [31:0] mask;

        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations
        issue(1'b0, 9'd128, 27'b0_1_1000_0000_0000_0000_0000_000_0_0, mk(32'h40400000, 1'b0, 1'b0, 1'b0, 4));
        wait_idle();
        issue(1'b0, 9'd131, (27'd1 << 26) | (27'b001111 << 19), mk(32'h420F0000, 1'b0, 1'b0, 1'b0, 4));
        wait_idle();
        issue(1'b0, 9'd130, 27'd1 << 23, mk(32'h40000000, 1'b0, 1'b0, 1'b0, 6));
        wait_idle();
        issue(1'b0, 9'd127, (27'd1 << 25) | (27'h7FFFFF << 2) | 27'd2, mk(32'h40000000, 1'b0, 1'b0, 1'b1, 4));
        wait_idle();
        issue(1'b0, 9'd127, (27'd1 << 25) | (27'd1 << 2) | 27'd2, mk(32'h3F800002, 1'b0, 1'b0, 1'b1, 4));
        wait_idle();
        issue(1'b1, 9'd254, 27'd1 << 26, mk(32'hFF800000, 1'b1, 1'b0, 1'b1, 4));
        wait_idle();
        issue(1'b0, 9'd100, 27'd0, mk(32'h00000000, 1'b0, 1'b0, 1'b0, 3));
        wait_idle();

        // A start while busy must not create a second operation
        issue(1'b0, 9'd130, 27'd1 << 23, mk(32'h40000000, 1'b0, 1'b0, 1'b0, 6));
        sign = 1'b1; exp_v = 9'd200; mant = 27'd1 << 25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // A start in the done cycle must be ignored
        issue(1'b0, 9'd128, 27'b0_1_1000_0000_0000_0000_0000_000_0_0, mk(32'h40400000, 1'b0, 1'b0, 1'b0, 4));
        n = 0;
        while (!done_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("timeout_done", 64'd1, 64'd0);
        sign = 1'b0; exp_v = 9'd128; mant = 27'd1 << 25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("busy_after_done_start", 64'(busy_o), 64'd0);
            @(negedge clk);
        end

        // Reset in the middle of a long left-normalization run
        issue(1'b0, 9'd130, 27'd1 << 10, mk(32'h0, 1'b0, 1'b0, 1'b0, 19));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check_zero_outputs("midop_reset");
        @(negedge clk);
        // Release reset with a start in the same cycle
        @(negedge clk);
        rst_n = 1'b1;
        sign = 1'b0; exp_v = 9'd128; mant = 27'b0_1_1000_0000_0000_0000_0000_000_0_0; start = 1'b1;
        mon_x = mk(32'h40400000, 1'b0, 1'b0, 1'b0, 4);
        mon_x.t0 = cyc;
        sb.push_back(mon_x);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Randomized vectors against the reference model
        for (int i = 0; i < 250; i++) begin
            s   = 1'($urandom);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       e = 9'($urandom_range(0, 6));
                1:       e = 9'($urandom_range(118, 136));
                2:       e = 9'($urandom_range(240, 262));
                default: e = 9'($urandom_range(0, 511));
            endcase
            p = int'($urandom_range(0, 27));
            if (p == 27) begin
                m = 27'd0;
            end else begin
                mask = (32'd1 << (p + 1)) - 32'd1;
                m    = 27'(($urandom & mask) | (32'd1 << p));
            end
            issue(s, e, m, model(s, e, m));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
